// File: rtl/execute_stage_if.sv
// Bundles the ID/EX inputs and EX/MEM outputs of the RV32I execute stage into one port.
// master drives the decode-side signals; slave is the execute stage itself.
interface execute_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] RD1E;
    logic [WORD_SIZE-1:0] RD2E;
    logic [WORD_SIZE-1:0] PCE;
    logic [WORD_SIZE-1:0] PCPlus4E;
    logic [WORD_SIZE-1:0] ImmExtE;
    logic [4:0]           RdE;
    logic                 RegWriteE;
    logic                 MemWriteE;
    logic                 JumpE;
    logic                 BranchE;
    logic                 ALUSrcE;
    logic [1:0]           ResultSrcE;
    logic [2:0]           ALUControlE;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic [WORD_SIZE-1:0] ResultW;

    logic                 PCSrcE;
    logic [WORD_SIZE-1:0] PCTargetE;
    logic [WORD_SIZE-1:0] ALUResultM;
    logic [WORD_SIZE-1:0] WriteDataM;
    logic [WORD_SIZE-1:0] PCPlus4M;
    logic [4:0]           RdM;
    logic                 RegWriteM;
    logic                 MemWriteM;
    logic [1:0]           ResultSrcM;
    logic                 StallE;

    modport master (
        output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE,
               RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
               RdM, RegWriteM, MemWriteM, ResultSrcM, StallE
    );

    modport slave (
        input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE,
               RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
               RdM, RegWriteM, MemWriteM, ResultSrcM, StallE
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and the EX/MEM register.
// Define EXEC_MUL_EN to build the multi-cycle multiplier (ALUControlE 111) and drive StallE.
module execute_stage #(
    parameter int WORD_SIZE  = 32,
    parameter int MUL_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave ex
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [WORD_SIZE-1:0] srcA_s;
    logic [WORD_SIZE-1:0] fwdB_s;
    logic [WORD_SIZE-1:0] srcB_s;
    logic [WORD_SIZE-1:0] aluResult_s;
    logic                 zero_s;
    logic                 stall_s;

    logic [WORD_SIZE-1:0] aluResultM_r;
    logic [WORD_SIZE-1:0] writeDataM_r;
    logic [WORD_SIZE-1:0] pcPlus4M_r;
    logic [4:0]           rdM_r;
    logic                 regWriteM_r;
    logic                 memWriteM_r;
    logic [1:0]           resultSrcM_r;

    // Forwarding muxes and ALU B-operand select
    always_comb begin
        srcA_s = ex.RD1E;
        fwdB_s = ex.RD2E;
        case (ex.ForwardAE)
            2'b01:   srcA_s = ex.ResultW;
            2'b10:   srcA_s = aluResultM_r;
            default: srcA_s = ex.RD1E;
        endcase
        case (ex.ForwardBE)
            2'b01:   fwdB_s = ex.ResultW;
            2'b10:   fwdB_s = aluResultM_r;
            default: fwdB_s = ex.RD2E;
        endcase
        if (ex.ALUSrcE) begin
            srcB_s = ex.ImmExtE;
        end else begin
            srcB_s = fwdB_s;
        end
    end

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    mul_state_e           mulState_r;
    mul_state_e           mulNext_s;
    logic [CW-1:0]        mulCount_r;
    logic [CW-1:0]        mulCountNext_s;
    logic [WORD_SIZE-1:0] mulA_r;
    logic [WORD_SIZE-1:0] mulB_r;
    logic [WORD_SIZE-1:0] mulProduct_s;
    logic                 mulStart_s;
    logic                 stallRaw_s;

    // Product of the operands captured when the MUL entered the FSM
    always_comb begin
        mulProduct_s = mulA_r * mulB_r;
    end

    // Multiplier next-state, countdown and stall decode. The counter is loaded with
    // MUL_CYCLES-1; the BUSY cycle whose decrement reaches zero is the last stalled one,
    // so the IDLE cycle plus the BUSY cycles stall for exactly MUL_CYCLES cycles.
    always_comb begin
        mulNext_s      = mulState_r;
        mulCountNext_s = mulCount_r;
        mulStart_s     = 1'b0;
        stallRaw_s     = 1'b0;
        case (mulState_r)
            MUL_IDLE: begin
                if (ex.ALUControlE == OP_MUL) begin
                    mulNext_s      = MUL_BUSY;
                    mulCountNext_s = CW'(MUL_CYCLES - 1);
                    mulStart_s     = 1'b1;
                    stallRaw_s     = 1'b1;
                end else begin
                    mulNext_s      = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                stallRaw_s     = 1'b1;
                mulCountNext_s = mulCount_r - CW'(1);
                if (mulCount_r == CW'(1)) begin
                    mulNext_s = MUL_DONE;
                end else begin
                    mulNext_s = MUL_BUSY;
                end
            end
            MUL_DONE: begin
                mulNext_s = MUL_IDLE;
            end
            default: begin
                mulNext_s = MUL_IDLE;
            end
        endcase
    end

    // Multiplier state, counter and operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mulState_r <= MUL_IDLE;
            mulCount_r <= {CW{1'b0}};
            mulA_r     <= {WORD_SIZE{1'b0}};
            mulB_r     <= {WORD_SIZE{1'b0}};
        end else begin
            mulState_r <= mulNext_s;
            mulCount_r <= mulCountNext_s;
            if (mulStart_s) begin
                mulA_r <= srcA_s;
                mulB_r <= srcB_s;
            end
        end
    end

    // Reset keeps StallE low even if a MUL is sitting in EX
    assign stall_s = stallRaw_s & ~rst;
`else
    assign stall_s = 1'b0;
`endif

    // ALU
    always_comb begin
        aluResult_s = {WORD_SIZE{1'b0}};
        case (ex.ALUControlE)
            OP_ADD: aluResult_s = srcA_s + srcB_s;
            OP_SUB: aluResult_s = srcA_s - srcB_s;
            OP_AND: aluResult_s = srcA_s & srcB_s;
            OP_OR:  aluResult_s = srcA_s | srcB_s;
            OP_XOR: aluResult_s = srcA_s ^ srcB_s;
            OP_SLT: begin
                if ($signed(srcA_s) < $signed(srcB_s)) begin
                    aluResult_s = {{(WORD_SIZE-1){1'b0}}, 1'b1};
                end else begin
                    aluResult_s = {WORD_SIZE{1'b0}};
                end
            end
            OP_SLL: aluResult_s = srcA_s << srcB_s[4:0];
`ifdef EXEC_MUL_EN
            OP_MUL: aluResult_s = mulProduct_s;
`else
            OP_MUL: aluResult_s = {WORD_SIZE{1'b0}};
`endif
            default: aluResult_s = {WORD_SIZE{1'b0}};
        endcase
    end

    assign zero_s       = (aluResult_s == {WORD_SIZE{1'b0}});
    assign ex.PCSrcE    = ((ex.BranchE & zero_s) | ex.JumpE) & ~stall_s;
    assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
    assign ex.StallE    = stall_s;

    // EX/MEM pipeline register; a stalled cycle loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            aluResultM_r <= {WORD_SIZE{1'b0}};
            writeDataM_r <= {WORD_SIZE{1'b0}};
            pcPlus4M_r   <= {WORD_SIZE{1'b0}};
            rdM_r        <= 5'd0;
            regWriteM_r  <= 1'b0;
            memWriteM_r  <= 1'b0;
            resultSrcM_r <= 2'b00;
        end else if (stall_s) begin
            aluResultM_r <= {WORD_SIZE{1'b0}};
            writeDataM_r <= {WORD_SIZE{1'b0}};
            pcPlus4M_r   <= {WORD_SIZE{1'b0}};
            rdM_r        <= 5'd0;
            regWriteM_r  <= 1'b0;
            memWriteM_r  <= 1'b0;
            resultSrcM_r <= 2'b00;
        end else begin
            aluResultM_r <= aluResult_s;
            writeDataM_r <= fwdB_s;
            pcPlus4M_r   <= ex.PCPlus4E;
            rdM_r        <= ex.RdE;
            regWriteM_r  <= ex.RegWriteE;
            memWriteM_r  <= ex.MemWriteE;
            resultSrcM_r <= ex.ResultSrcE;
        end
    end

    assign ex.ALUResultM = aluResultM_r;
    assign ex.WriteDataM = writeDataM_r;
    assign ex.PCPlus4M   = pcPlus4M_r;
    assign ex.RdM        = rdM_r;
    assign ex.RegWriteM  = regWriteM_r;
    assign ex.MemWriteM  = memWriteM_r;
    assign ex.ResultSrcM = resultSrcM_r;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected EX/MEM contents are queued at issue
// and compared when the register produces them. Multiplier tests need EXEC_MUL_EN.
module tb_execute_stage;
    localparam int WS         = 32;
    localparam int MUL_CYCLES = 8;

    typedef struct packed {
        logic [WS-1:0] alu;
        logic [WS-1:0] wd;
        logic [WS-1:0] pc4;
        logic [4:0]    rd;
        logic          rw;
        logic          mw;
        logic [1:0]    rs;
    } exmem_t;

    logic clk = 1'b0;
    logic rst;
    int vec_count  = 0;
    int miss_count = 0;
    exmem_t sb_q[$];
    logic [WS-1:0] alu_m_model = 32'd0;

    always #5 clk = ~clk;

    execute_stage_if #(.WORD_SIZE(WS)) bus ();

    execute_stage #(.WORD_SIZE(WS), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [1:0] sel, input logic [31:0] rf,
                                              input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            3'd0: return a + b;
            3'd1: return a + (~b) + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            3'd6: begin
                wide = {32'd0, a} << b[4:0];
                return wide[31:0];
            end
            default: begin
`ifdef EXEC_MUL_EN
                wide = {32'd0, a} * {32'd0, b};
                return wide[31:0];
`else
                return 32'd0;
`endif
            end
        endcase
    endfunction

    task automatic clear_inputs();
        bus.RD1E = 32'd0; bus.RD2E = 32'd0; bus.PCE = 32'd0; bus.PCPlus4E = 32'd0;
        bus.ImmExtE = 32'd0; bus.RdE = 5'd0; bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0;
        bus.JumpE = 1'b0; bus.BranchE = 1'b0; bus.ALUSrcE = 1'b0; bus.ResultSrcE = 2'b00;
        bus.ALUControlE = 3'b000; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
        bus.ResultW = 32'd0;
    endtask

    task automatic compare_exmem(input exmem_t e);
        check_eq("alu_result", bus.ALUResultM, e.alu);
        check_eq("write_data", bus.WriteDataM, e.wd);
        check_eq("pc_plus4",   bus.PCPlus4M, e.pc4);
        check_eq("rd",         32'(bus.RdM), 32'(e.rd));
        check_eq("reg_write",  32'(bus.RegWriteM), 32'(e.rw));
        check_eq("mem_write",  32'(bus.MemWriteM), 32'(e.mw));
        check_eq("result_src", 32'(bus.ResultSrcM), 32'(e.rs));
        alu_m_model = e.alu;
    endtask

    // Inputs are already driven: check the combinational outputs and queue the EX/MEM image
    task automatic issue();
        logic [31:0] a, bf, b, r;
        logic pcs;
        exmem_t e;
        #1;
        a   = fwd_model(bus.ForwardAE, bus.RD1E, bus.ResultW, alu_m_model);
        bf  = fwd_model(bus.ForwardBE, bus.RD2E, bus.ResultW, alu_m_model);
        b   = bus.ALUSrcE ? bus.ImmExtE : bf;
        r   = alu_model(bus.ALUControlE, a, b);
        pcs = (bus.BranchE && (r == 32'd0)) || bus.JumpE;
        check_eq("pc_src",    32'(bus.PCSrcE), 32'(pcs));
        check_eq("pc_target", bus.PCTargetE, bus.PCE + bus.ImmExtE);
        check_eq("stall",     32'(bus.StallE), 32'd0);
        e = '{alu: r, wd: bf, pc4: bus.PCPlus4E, rd: bus.RdE, rw: bus.RegWriteE,
              mw: bus.MemWriteE, rs: bus.ResultSrcE};
        sb_q.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) compare_exmem(sb_q.pop_front());
    endtask

    task automatic run_op();
        issue();
        advance();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_alu"},   bus.ALUResultM, 32'd0);
        check_eq({tag, "_wd"},    bus.WriteDataM, 32'd0);
        check_eq({tag, "_pc4"},   bus.PCPlus4M, 32'd0);
        check_eq({tag, "_ctl"},   {25'd0, bus.RdM, bus.RegWriteM, bus.MemWriteM}, 32'd0);
        check_eq({tag, "_rs"},    32'(bus.ResultSrcM), 32'd0);
        check_eq({tag, "_stall"}, 32'(bus.StallE), 32'd0);
    endtask

`ifdef EXEC_MUL_EN
    // MUL inputs are already driven; returns just after the product lands in EX/MEM
    task automatic run_mul(input bit disturb);
        exmem_t e;
        int cyc = 0;
        int stalls = 0;
        int bubbles = 0;
        bit seen = 1'b0;
        #1;
        e = '{alu: alu_model(3'b111, bus.RD1E, bus.RD2E), wd: bus.RD2E, pc4: bus.PCPlus4E,
              rd: bus.RdE, rw: bus.RegWriteE, mw: bus.MemWriteE, rs: bus.ResultSrcE};
        sb_q.push_back(e);
        check_eq("mul_stall_first", 32'(bus.StallE), 32'd1);
        check_eq("mul_pcsrc_mask",  32'(bus.PCSrcE), 32'd0);
        if (bus.StallE) stalls++;
        while (!seen && cyc < MUL_CYCLES + 4) begin
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 2) bus.RD1E = 32'd100;
            if (bus.RegWriteM) begin
                seen = 1'b1;
            end else begin
                if (bus.RdM == 5'd0 && !bus.MemWriteM && bus.ResultSrcM == 2'b00) bubbles++;
                if (bus.StallE) stalls++;
            end
        end
        check_eq("mul_latency", 32'(cyc), 32'(MUL_CYCLES + 1));
        check_eq("mul_stalls",  32'(stalls), 32'(MUL_CYCLES));
        check_eq("mul_bubbles", 32'(bubbles), 32'(MUL_CYCLES));
        compare_exmem(sb_q.pop_front());
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // ADD 5+7 -> x3
        clear_inputs();
        bus.RD1E = 32'd5; bus.RD2E = 32'd7; bus.RegWriteE = 1'b1; bus.RdE = 5'd3;
        bus.PCPlus4E = 32'h8;
        run_op();
        check_eq("add_value", bus.ALUResultM, 32'd12);

        // Forwarding: A from EX/MEM (0x10), B from writeback (0x20), SUB
        clear_inputs();
        bus.RD1E = 32'h10;
        run_op();
        bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'h20;
        bus.RD1E = 32'hDEAD; bus.RD2E = 32'hBEEF; bus.ALUControlE = 3'b001;
        bus.RegWriteE = 1'b1; bus.RdE = 5'd7; bus.ResultSrcE = 2'b01;
        run_op();
        check_eq("fwd_sub", bus.ALUResultM, 32'hFFFF_FFF0);
        check_eq("fwd_wd",  bus.WriteDataM, 32'h20);

        // BEQ taken then not taken
        clear_inputs();
        bus.RD1E = 32'd9; bus.RD2E = 32'd9; bus.ALUControlE = 3'b001; bus.BranchE = 1'b1;
        bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8; bus.MemWriteE = 1'b1;
        issue();
        check_eq("beq_taken",  32'(bus.PCSrcE), 32'd1);
        check_eq("beq_target", bus.PCTargetE, 32'hF8);
        advance();
        bus.RD2E = 32'd8;
        issue();
        check_eq("beq_not_taken", 32'(bus.PCSrcE), 32'd0);
        advance();

        // SLT signed and SLL by 31
        clear_inputs();
        bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.ALUControlE = 3'b101;
        run_op();
        check_eq("slt_value", bus.ALUResultM, 32'd1);
        bus.RD1E = 32'd1; bus.ImmExtE = 32'd31; bus.ALUSrcE = 1'b1; bus.ALUControlE = 3'b110;
        run_op();
        check_eq("sll_value", bus.ALUResultM, 32'h8000_0000);

        // Jump with a non-zero result still selects the target
        clear_inputs();
        bus.JumpE = 1'b1; bus.RD1E = 32'd3; bus.PCE = 32'h40; bus.ImmExtE = 32'h20;
        bus.PCPlus4E = 32'h44; bus.RegWriteE = 1'b1; bus.RdE = 5'd1; bus.ResultSrcE = 2'b10;
        issue();
        check_eq("jal_pcsrc", 32'(bus.PCSrcE), 32'd1);
        advance();

`ifndef EXEC_MUL_EN
        // Without the multiplier, op 111 is a single-cycle zero result
        clear_inputs();
        bus.RD1E = 32'd6; bus.RD2E = 32'd7; bus.ALUControlE = 3'b111; bus.RegWriteE = 1'b1;
        bus.RdE = 5'd9;
        run_op();
        check_eq("mul_off_value", bus.ALUResultM, 32'd0);
`endif

        // Random mix of operations and forwarding selects
        for (int i = 0; i < 24; i++) begin
            bus.RD1E = $urandom(); bus.RD2E = $urandom(); bus.ImmExtE = $urandom();
            bus.PCE = $urandom(); bus.PCPlus4E = $urandom(); bus.ResultW = $urandom();
            bus.RdE = 5'($urandom_range(0, 31));
            bus.RegWriteE = 1'($urandom_range(0, 1)); bus.MemWriteE = 1'($urandom_range(0, 1));
            bus.BranchE = 1'($urandom_range(0, 1)); bus.JumpE = 1'($urandom_range(0, 1));
            bus.ALUSrcE = 1'($urandom_range(0, 1)); bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.ForwardAE = 2'($urandom_range(0, 3)); bus.ForwardBE = 2'($urandom_range(0, 3));
`ifdef EXEC_MUL_EN
            bus.ALUControlE = 3'($urandom_range(0, 6));
`else
            bus.ALUControlE = 3'($urandom_range(0, 7));
`endif
            run_op();
        end

`ifdef EXEC_MUL_EN
        // 0x10000 * 0x10000 wraps to 0; back-to-back 6*7 with RD1E disturbed mid-operation
        clear_inputs();
        bus.RD1E = 32'h10000; bus.RD2E = 32'h10000; bus.ALUControlE = 3'b111;
        bus.RegWriteE = 1'b1; bus.RdE = 5'd5; bus.PCPlus4E = 32'h204; bus.JumpE = 1'b1;
        run_mul(1'b0);
        check_eq("mul_wrap", bus.ALUResultM, 32'd0);
        clear_inputs();
        bus.RD1E = 32'd6; bus.RD2E = 32'd7; bus.ALUControlE = 3'b111;
        bus.RegWriteE = 1'b1; bus.RdE = 5'd6; bus.PCPlus4E = 32'h208;
        run_mul(1'b1);
        check_eq("mul_42", bus.ALUResultM, 32'd42);

        // Reset while BUSY aborts the multiply
        clear_inputs();
        bus.RD1E = 32'd3; bus.RD2E = 32'd5; bus.ALUControlE = 3'b111;
        bus.RegWriteE = 1'b1; bus.RdE = 5'd8;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_busy_stall", 32'(bus.StallE), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        #1;
        check_all_zero("rst_busy");
`else
        // Reset in mid-stream clears EX/MEM
        clear_inputs();
        bus.RD1E = 32'd5; bus.RD2E = 32'd7; bus.RegWriteE = 1'b1; bus.RdE = 5'd3;
        run_op();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        #1;
        check_all_zero("rst_mid");
`endif
        sb_q.delete();
        alu_m_model = 32'd0;
        for (int i = 0; i < MUL_CYCLES + 3; i++) begin
            run_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
